rfblackwidow_pte_wb_responder: RTL

RFBLACKWIDOW_PTE_WB_RESPONDER -- requirements
Module: rfBlackWidow_pte_wb_responder

---
 rtl/rfblackwidow_pte_wb_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rfblackwidow_pte_wb_responder.sv
// rfblackwidow_pte_wb_responder: buffers TLB PTE/PMT write-backs and drains them to memory as 128-bit writes
module rfblackwidow_pte_wb_responder #(
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         s_cyc_i,
    input  logic [31:0]  s_adr_i,
    input  logic [127:0] s_dat_i,
    output logic         s_ack_o,
    output logic         m_cyc_o,
    output logic         m_stb_o,
    output logic         m_we_o,
    output logic [15:0]  m_sel_o,
    output logic [31:0]  m_adr_o,
    output logic [127:0] m_dat_o,
    input  logic         m_ack_i,
    output logic         busy_o,
    output logic         err_o,
    input  logic         err_clr_i,
    output logic [15:0]  wb_count_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, TMO_DROP} state_t;

    state_t        state, state_nx;
    logic [27:0]   adr_q [DEPTH];
    logic [127:0]  dat_q [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, hit_idx;
    logic [AW:0]   count;
    logic [7:0]    timer;
    logic          guard, hit, full, pop, push, acc, fwd, issue;
    logic          adr_lo_unused;

    // Line offset bits never reach memory; writes are always whole 16-byte entries.
    assign adr_lo_unused = ^s_adr_i[3:0];

    // Coalesce lookup: any valid entry matches, except the head once it is on (or leaving) the bus.
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (s_adr_i[31:4] == adr_q[i] && {1'b0, AW'(i) - rd_ptr} < count &&
                !(state != IDLE && AW'(i) == rd_ptr)) begin
                hit = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    // Next state plus accept/pop decisions; a pop frees a slot for a same-edge push even when full.
    always_comb begin
        full = count == (AW+1)'(DEPTH);
        pop = (state == REQ && m_ack_i) || state == TMO_DROP;
        acc = s_cyc_i && !guard && (hit || !full || pop);
        push = acc && !hit;
        fwd = acc && hit && state == IDLE && hit_idx == rd_ptr;
        state_nx = state == IDLE ? (count != '0 ? REQ : IDLE) :
                   state == REQ  ? (m_ack_i ? IDLE : timer == 8'(TMO - 1) ? TMO_DROP : REQ) :
                   IDLE;
        issue = state == IDLE && state_nx == REQ;
        busy_o = count != '0 || state != IDLE;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nx;
    end

    // FIFO pointers, occupancy and the slave-side handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            s_ack_o <= 1'b0;
            guard   <= 1'b0;
        end else begin
            rd_ptr  <= rd_ptr + AW'(pop);
            wr_ptr  <= wr_ptr + AW'(push);
            count   <= count + (AW+1)'(push) - (AW+1)'(pop);
            s_ack_o <= acc;
            guard   <= acc || (guard && s_cyc_i);
        end
    end

    // Entry storage: allocate on push, overwrite in place on a coalesce hit.
    always_ff @(posedge clk_i) begin
        if (push) begin
            adr_q[wr_ptr] <= s_adr_i[31:4];
            dat_q[wr_ptr] <= s_dat_i;
        end else if (acc) begin
            dat_q[hit_idx] <= s_dat_i;
        end
    end

    // Memory bus, timeout timer, commit counter and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_sel_o    <= '0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
            timer      <= '0;
            wb_count_o <= '0;
            err_o      <= 1'b0;
        end else begin
            m_cyc_o    <= state_nx == REQ;
            m_stb_o    <= state_nx == REQ;
            m_we_o     <= state_nx == REQ;
            m_sel_o    <= {16{state_nx == REQ}};
            timer      <= (state == REQ && state_nx == REQ) ? timer + 8'd1 : 8'd0;
            wb_count_o <= wb_count_o + 16'(state == REQ && m_ack_i);
            err_o      <= state == TMO_DROP || (err_o && !err_clr_i);
            if (issue) begin
                m_adr_o <= {adr_q[rd_ptr], 4'h0};
                m_dat_o <= fwd ? s_dat_i : dat_q[rd_ptr];
            end
        end
    end
endmodule
